// File: rtl/cmd_frame_rx.sv
// Host command link endpoint: 8N1 UART receiver assembling 3-byte frames plus a single-byte response transmitter.
// Optional inter-byte gap timeout is compiled in with `define CMD_TIMEOUT_EN.
module cmd_frame_rx #(
    parameter int unsigned BAUD_DIV = 2604,
    parameter logic [21:0] TIMEOUT  = 22'd2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int unsigned   CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frm_state_t;

    logic rx_meta, rx_sync, rx_prev, rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_byte;
    logic            rx_tick, rx_cnt_clr, rx_bit_clr, rx_shift_en, byte_done, frame_err;

    // Start bit is qualified at half a bit; every later sample lands mid-bit.
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_cnt_clr  = (rx_state == RX_IDLE) || rx_tick;
        rx_bit_clr  = (rx_state == RX_START);
        rx_shift_en = (rx_state == RX_DATA) && rx_tick;
        byte_done   = (rx_state == RX_STOP) && rx_tick && rx_sync;
        frame_err   = (rx_state == RX_STOP) && rx_tick && !rx_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_byte <= '0;
        end else begin
            rx_cnt <= rx_cnt_clr ? '0 : rx_cnt + CW'(1);
            if (rx_bit_clr)       rx_bit <= '0;
            else if (rx_shift_en) rx_bit <= rx_bit + 3'd1;
            if (rx_shift_en)      rx_byte <= {rx_sync, rx_byte[7:1]};
        end
    end

    frm_state_t frm_state, frm_next;
    logic       timeout, ld_cmd, ld_hi, ld_done;
    logic [7:0] cmd_sh, hi_sh;

`ifdef CMD_TIMEOUT_EN
    logic [21:0] gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                gap_cnt <= '0;
        else if (byte_done || frm_state == WAIT_CMD) gap_cnt <= '0;
        else                                       gap_cnt <= gap_cnt + 22'd1;
    end

    assign timeout = (frm_state != WAIT_CMD) && (gap_cnt == TIMEOUT);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frm_state <= WAIT_CMD;
        else        frm_state <= frm_next;
    end

    always_comb begin
        frm_next = frm_state;
        if (frame_err || timeout) begin
            frm_next = WAIT_CMD;
        end else if (byte_done) begin
            case (frm_state)
                WAIT_CMD: frm_next = WAIT_HI;
                WAIT_HI:  frm_next = WAIT_LO;
                default:  frm_next = WAIT_CMD;
            endcase
        end
    end

    always_comb begin
        ld_cmd  = byte_done && !timeout && (frm_state == WAIT_CMD);
        ld_hi   = byte_done && !timeout && (frm_state == WAIT_HI);
        ld_done = byte_done && !timeout && (frm_state == WAIT_LO);
    end

    // Frame completion outranks clr_cmd_rdy so a frame landing with a clear is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_sh  <= '0;
            hi_sh   <= '0;
            cmd     <= '0;
            data    <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (ld_cmd) cmd_sh <= rx_byte;
            if (ld_hi)  hi_sh  <= rx_byte;
            if (ld_done) begin
                cmd  <= cmd_sh;
                data <= {hi_sh, rx_byte};
            end
            if (ld_done)                    cmd_rdy <= 1'b1;
            else if (ld_cmd || clr_cmd_rdy) cmd_rdy <= 1'b0;
        end
    end

    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_tick, tx_load, tx_start_tick, tx_data_tick, tx_done;

    assign tx_tick = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (send_resp) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_load       = (tx_state == TX_IDLE) && send_resp;
        tx_start_tick = (tx_state == TX_START) && tx_tick;
        tx_data_tick  = (tx_state == TX_DATA) && tx_tick;
        tx_done       = (tx_state == TX_STOP) && tx_tick;
    end

    // Ones shifted in behind the data surface as the stop bit after the last data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else begin
            tx_cnt <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + CW'(1);
            if (tx_load) begin
                tx_shift  <= resp;
                tx_bit    <= '0;
                TX        <= 1'b0;
                resp_sent <= 1'b0;
            end
            if (tx_start_tick) TX <= tx_shift[0];
            if (tx_data_tick) begin
                tx_shift <= {1'b1, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
                TX       <= tx_shift[1];
            end
            if (tx_done) begin
                TX        <= 1'b1;
                resp_sent <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Directed bench for cmd_frame_rx at a shortened bit period; timeout expectations follow CMD_TIMEOUT_EN.
module tb_cmd_frame_rx;

    localparam int B        = 16;
    localparam int DONE_OFS = 2 + B / 2 + 9 * B;

    logic        clk, rst_n, rx_line, tx_line;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;
    logic [7:0]  resp;
    logic        rdy_done, rdy_after;
    int          checks, fails;

    cmd_frame_rx #(.BAUD_DIV(B), .TIMEOUT(22'd400)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx_line), .TX(tx_line),
        .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called and returns 1 time unit after a rising edge; records cmd_rdy around the stop-bit sample.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic clr_at_end);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10 * B; c++) begin
            rx_line     = f[c / B];
            clr_cmd_rdy = clr_at_end && (c == DONE_OFS);
            if (c == DONE_OFS)     rdy_done  = cmd_rdy;
            if (c == DONE_OFS + 1) rdy_after = cmd_rdy;
            @(posedge clk); #1;
        end
        rx_line     = 1'b1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_line = 1'b1; clr_cmd_rdy = 1'b0; resp = '0; send_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (tx_line !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx_line); end
        checks++; if (cmd !== 8'h00) begin fails++; $display("FAIL reset_cmd: got %h expected 00", cmd); end
        checks++; if (data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", data); end
        checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
        checks++; if (resp_sent !== 1'b0) begin fails++; $display("FAIL reset_resp_sent: got %b expected 0", resp_sent); end
    endtask

    task automatic test_frame();
        send_byte(8'h05, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h2C, 1'b1, 1'b0);
        checks++; if (rdy_done !== 1'b0) begin fails++; $display("FAIL frame_rdy_early: got %b expected 0", rdy_done); end
        checks++; if (rdy_after !== 1'b1) begin fails++; $display("FAIL frame_rdy_latency: got %b expected 1", rdy_after); end
        checks++; if (cmd !== 8'h05) begin fails++; $display("FAIL frame_cmd: got %h expected 05", cmd); end
        checks++; if (data !== 16'h012C) begin fails++; $display("FAIL frame_data: got %h expected 012c", data); end
        pulse_clr();
        checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL clr_cmd_rdy: got %b expected 0", cmd_rdy); end
        checks++; if (data !== 16'h012C) begin fails++; $display("FAIL clr_data_hold: got %h expected 012c", data); end
        pulse_clr();
        checks++; if (cmd_rdy !== 1'b0 || cmd !== 8'h05) begin
            fails++; $display("FAIL clr_when_idle: got rdy=%b cmd=%h expected rdy=0 cmd=05", cmd_rdy, cmd);
        end
    endtask

    task automatic test_undefined_opcode();
        send_byte(8'h09, 1'b1, 1'b0);
        send_byte(8'h89, 1'b1, 1'b0);
        send_byte(8'h91, 1'b1, 1'b0);
        checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL undef_rdy: got %b expected 1", cmd_rdy); end
        checks++; if (cmd !== 8'h09) begin fails++; $display("FAIL undef_cmd: got %h expected 09", cmd); end
        checks++; if (data !== 16'h8991) begin fails++; $display("FAIL undef_data: got %h expected 8991", data); end
        pulse_clr();
    endtask

    task automatic test_framing_error();
        send_byte(8'h02, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL ferr_rdy: got %b expected 0", cmd_rdy); end
        checks++; if (cmd !== 8'h09 || data !== 16'h8991) begin
            fails++; $display("FAIL ferr_hold: got %h/%h expected 09/8991", cmd, data);
        end
        send_byte(8'h02, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h80, 1'b1, 1'b0);
        checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL ferr_recover_rdy: got %b expected 1", cmd_rdy); end
        checks++; if (cmd !== 8'h02) begin fails++; $display("FAIL ferr_recover_cmd: got %h expected 02", cmd); end
        checks++; if (data !== 16'hFF80) begin fails++; $display("FAIL ferr_recover_data: got %h expected ff80", data); end
    endtask

    task automatic test_clr_collision();
        send_byte(8'h0A, 1'b1, 1'b0);
        send_byte(8'h5B, 1'b1, 1'b0);
        checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL coll_pre_rdy: got %b expected 0", cmd_rdy); end
        send_byte(8'h6C, 1'b1, 1'b1);
        checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL coll_rdy: got %b expected 1", cmd_rdy); end
        checks++; if (cmd !== 8'h0A || data !== 16'h5B6C) begin
            fails++; $display("FAIL coll_frame: got %h/%h expected 0a/5b6c", cmd, data);
        end
        pulse_clr();
    endtask

    task automatic test_tx();
        logic [9:0] txf;
        txf = {1'b1, 8'hA5, 1'b0};
        resp = 8'hA5;
        send_resp = 1'b1;
        checks++; if (tx_line !== 1'b1) begin fails++; $display("FAIL tx_idle: got %b expected 1", tx_line); end
        @(posedge clk); #1;
        send_resp = 1'b0;
        for (int c = 0; c < 10 * B; c++) begin
            if (c == 0) begin
                checks++; if (tx_line !== 1'b0) begin fails++; $display("FAIL tx_fall_latency: got %b expected 0", tx_line); end
            end
            if (c % B == B / 2) begin
                checks++; if (tx_line !== txf[c / B]) begin
                    fails++; $display("FAIL tx_bit%0d: got %b expected %b", c / B, tx_line, txf[c / B]);
                end
            end
            if (c == 3 * B + 3) begin send_resp = 1'b1; resp = 8'h00; end
            if (c == 3 * B + 4) send_resp = 1'b0;
            if (c == 10 * B - 1) begin
                checks++; if (resp_sent !== 1'b0) begin fails++; $display("FAIL tx_sent_early: got %b expected 0", resp_sent); end
            end
            @(posedge clk); #1;
        end
        checks++; if (resp_sent !== 1'b1) begin fails++; $display("FAIL tx_sent: got %b expected 1", resp_sent); end
        checks++; if (tx_line !== 1'b1) begin fails++; $display("FAIL tx_idle_after: got %b expected 1", tx_line); end
        resp = 8'hA5;
        send_resp = 1'b1;
        @(posedge clk); #1;
        send_resp = 1'b0;
        checks++; if (resp_sent !== 1'b0) begin fails++; $display("FAIL tx_sent_clear: got %b expected 0", resp_sent); end
        repeat (10 * B + 2) @(posedge clk);
        #1;
        checks++; if (resp_sent !== 1'b1) begin fails++; $display("FAIL tx_sent_again: got %b expected 1", resp_sent); end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h11, 1'b1, 1'b0);
        resp = 8'hA5;
        send_resp = 1'b1;
        @(posedge clk); #1;
        send_resp = 1'b0;
        rx_line = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (tx_line !== 1'b0) begin fails++; $display("FAIL mid_tx_busy: got %b expected 0", tx_line); end
        #2;
        rst_n = 1'b0;
        rx_line = 1'b1;
        #1;
        checks++; if (tx_line !== 1'b1) begin fails++; $display("FAIL mid_tx_async: got %b expected 1", tx_line); end
        checks++; if (cmd !== 8'h00 || data !== 16'h0000) begin
            fails++; $display("FAIL mid_outputs: got %h/%h expected 00/0000", cmd, data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_byte(8'h07, 1'b1, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
        checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL mid_rdy: got %b expected 1", cmd_rdy); end
        checks++; if (cmd !== 8'h07 || data !== 16'h1234) begin
            fails++; $display("FAIL mid_frame: got %h/%h expected 07/1234", cmd, data);
        end
        pulse_clr();
    endtask

    task automatic test_timeout();
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
        logic        exp_rdy;
`ifdef CMD_TIMEOUT_EN
        exp_cmd = 8'h04; exp_data = 16'h0010; exp_rdy = 1'b1;
`else
        exp_cmd = 8'h03; exp_data = 16'h0400; exp_rdy = 1'b0;
`endif
        send_byte(8'h03, 1'b1, 1'b0);
        repeat (600) @(posedge clk);
        #1;
        send_byte(8'h04, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h10, 1'b1, 1'b0);
        checks++; if (cmd !== exp_cmd) begin fails++; $display("FAIL gap_cmd: got %h expected %h", cmd, exp_cmd); end
        checks++; if (data !== exp_data) begin fails++; $display("FAIL gap_data: got %h expected %h", data, exp_data); end
        checks++; if (cmd_rdy !== exp_rdy) begin fails++; $display("FAIL gap_rdy: got %b expected %b", cmd_rdy, exp_rdy); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rdy_done  = 1'bx;
        rdy_after = 1'bx;
        test_reset();
        test_frame();
        test_undefined_opcode();
        test_framing_error();
        test_clr_collision();
        test_tx();
        test_reset_midframe();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
